hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage MIPS pipeline. It compares Id-stage source registers and their Tuse against the Ex/Mem destination registers and their Tnew. It tracks the multi-cycle mult/div unit with an internal busy counter. It sequences exception/eret flushes. Its outputs drive the IfId stall/flush inputs, the IdEx bubble insertion and the md-unit start gating.

---
 rtl/hazard_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Stall/flush controller for the five-stage MIPS pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_Id,
  input  logic [4:0]       rt_Id,
  input  logic [1:0]       tuseRs_Id,
  input  logic [1:0]       tuseRt_Id,
  input  logic [4:0]       grfWa_Ex,
  input  logic [4:0]       grfWa_Mem,
  input  logic [1:0]       tnew_Ex,
  input  logic [1:0]       tnew_Mem,
  input  logic             mdUse_Id,
  input  logic             mdStart_Ex,
  input  logic             mdIsDiv_Ex,
  input  logic             excReq_Mem,
  input  logic             eret_Mem,
  output logic             ifStall,
  output logic             idFlush,
  output logic             flush_Mem,
  output logic             mdGo,
  output logic             mdBusy,
  output logic [3:0]       mdCount,
  output logic [CNT_W-1:0] stallCnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [0:0]       state_q, state_d;
  logic [3:0]       mdCount_q, mdCount_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

  logic stallRs, stallRt, dataStall, flush, stall;

  // Register 0 is hardwired to zero, so it can never carry a real dependency.
  assign stallRs = (rs_Id != 5'd0) &
                   (((rs_Id == grfWa_Ex)  & (tnew_Ex  > tuseRs_Id)) |
                    ((rs_Id == grfWa_Mem) & (tnew_Mem > tuseRs_Id)));
  assign stallRt = (rt_Id != 5'd0) &
                   (((rt_Id == grfWa_Ex)  & (tnew_Ex  > tuseRt_Id)) |
                    ((rt_Id == grfWa_Mem) & (tnew_Mem > tuseRt_Id)));
  assign dataStall = stallRs | stallRt;

  assign flush  = excReq_Mem | eret_Mem;
  assign mdGo   = mdStart_Ex & ~flush & (state_q == IDLE);
  assign mdBusy = (state_q == BUSY) | mdGo;
  assign stall  = ~flush & (dataStall | (mdUse_Id & mdBusy));

  assign ifStall   = stall;
  assign idFlush   = stall;
  assign flush_Mem = flush;
  assign mdCount   = mdCount_q;
  assign stallCnt  = stallCnt_q;

  always_comb begin
    state_d   = state_q;
    mdCount_d = mdCount_q;
    case (state_q)
      IDLE: begin
        if (mdGo) begin
          mdCount_d = mdIsDiv_Ex ? DIV_LOAD : MULT_LOAD;
          state_d   = BUSY;
        end
      end
      default: begin
        // A flush does not abort a running operation; it drains to completion.
        if (mdCount_q == 4'd1) begin
          mdCount_d = 4'd0;
          state_d   = IDLE;
        end else begin
          mdCount_d = mdCount_q - 4'd1;
        end
      end
    endcase
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (stall && (stallCnt_q != {CNT_W{1'b1}})) begin
      stallCnt_d = stallCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mdCount_q  <= 4'd0;
      stallCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mdCount_q  <= mdCount_d;
      stallCnt_q <= stallCnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed and randomized checks of hazard_ctrl against a cycle model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int CW   = 4;
  localparam int MULT = 5;
  localparam int DIV  = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    rs_Id, rt_Id, grfWa_Ex, grfWa_Mem;
  logic [1:0]    tuseRs_Id, tuseRt_Id, tnew_Ex, tnew_Mem;
  logic          mdUse_Id, mdStart_Ex, mdIsDiv_Ex, excReq_Mem, eret_Mem;
  logic          ifStall, idFlush, flush_Mem, mdGo, mdBusy;
  logic [3:0]    mdCount;
  logic [CW-1:0] stallCnt;

  hazard_ctrl #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .rs_Id(rs_Id), .rt_Id(rt_Id), .tuseRs_Id(tuseRs_Id), .tuseRt_Id(tuseRt_Id),
    .grfWa_Ex(grfWa_Ex), .grfWa_Mem(grfWa_Mem), .tnew_Ex(tnew_Ex), .tnew_Mem(tnew_Mem),
    .mdUse_Id(mdUse_Id), .mdStart_Ex(mdStart_Ex), .mdIsDiv_Ex(mdIsDiv_Ex),
    .excReq_Mem(excReq_Mem), .eret_Mem(eret_Mem),
    .ifStall(ifStall), .idFlush(idFlush), .flush_Mem(flush_Mem), .mdGo(mdGo),
    .mdBusy(mdBusy), .mdCount(mdCount), .stallCnt(stallCnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: the md unit is described by the cycle it started and the last cycle it
  // stays busy; the stall counter is a plain saturating integer.
  int cyc       = 0;
  int start_cyc = -1;
  int busy_end  = -1;
  int scnt      = 0;

  function automatic bit hz(input logic [4:0] src, input logic [1:0] tuse);
    logic [4:0] wa [2];
    int         tn [2];
    wa[0] = grfWa_Ex;  tn[0] = int'(tnew_Ex);
    wa[1] = grfWa_Mem; tn[1] = int'(tnew_Mem);
    if (src == 5'd0) return 1'b0;
    for (int p = 0; p < 2; p++)
      if (wa[p] == src && tn[p] > int'(tuse)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_clear();
    start_cyc = -1;
    busy_end  = -1;
    scnt      = 0;
  endfunction

  // Evaluate one cycle: optional async reset pulse between edges, model check, model update.
  task automatic step(input bit pulse_rst);
    bit prev_busy, fl, go, busy, st;
    int exp_cnt;
    if (pulse_rst) begin
      #1 reset = 1'b1;
      #1 reset = 1'b0;
      model_clear();
    end
    #1;
    prev_busy = (cyc > start_cyc) && (cyc <= busy_end);
    exp_cnt   = prev_busy ? (busy_end - cyc + 1) : 0;
    fl   = excReq_Mem | eret_Mem;
    go   = mdStart_Ex & ~fl & ~prev_busy;
    busy = prev_busy | go;
    st   = ~fl & (hz(rs_Id, tuseRs_Id) | hz(rt_Id, tuseRt_Id) | (mdUse_Id & busy));
    chk("ifStall",   32'(ifStall),   32'(st));
    chk("idFlush",   32'(idFlush),   32'(st));
    chk("flush_Mem", 32'(flush_Mem), 32'(fl));
    chk("mdGo",      32'(mdGo),      32'(go));
    chk("mdBusy",    32'(mdBusy),    32'(busy));
    chk("mdCount",   32'(mdCount),   32'(exp_cnt));
    chk("stallCnt",  32'(stallCnt),  32'(scnt));
    if (go) begin
      start_cyc = cyc;
      busy_end  = cyc + (mdIsDiv_Ex ? DIV : MULT);
    end
    if (st && scnt < (1 << CW) - 1) scnt++;
    cyc++;
  endtask

  task automatic clear_inputs();
    rs_Id = 0; rt_Id = 0; tuseRs_Id = 0; tuseRt_Id = 0;
    grfWa_Ex = 0; grfWa_Mem = 0; tnew_Ex = 0; tnew_Mem = 0;
    mdUse_Id = 0; mdStart_Ex = 0; mdIsDiv_Ex = 0; excReq_Mem = 0; eret_Mem = 0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();

    // Reset state, all inputs zero
    step(1'b0);
    chk("rst_outputs", {25'd0, ifStall, idFlush, flush_Mem, mdGo, mdBusy, mdCount == 4'd0, stallCnt == '0}, 32'd3);
    @(negedge clk);

    // Load-use via Ex, then via Mem, then resolved
    rs_Id = 8; tuseRs_Id = 0; grfWa_Ex = 8; tnew_Ex = 2;
    step(1'b0); chk("loaduse_ex", 32'(ifStall), 32'd1);
    @(negedge clk);
    grfWa_Ex = 0; grfWa_Mem = 8; tnew_Mem = 1;
    step(1'b0); chk("loaduse_mem", 32'(ifStall), 32'd1);
    @(negedge clk);
    tnew_Mem = 0;
    step(1'b0); chk("loaduse_done", 32'(ifStall), 32'd0);
    @(negedge clk);

    // Register zero never stalls; unused operand (tuse=3) never stalls
    clear_inputs(); tnew_Ex = 2;
    step(1'b0); chk("reg_zero", 32'(ifStall), 32'd0);
    @(negedge clk);
    rt_Id = 9; grfWa_Ex = 9; tnew_Ex = 3; tuseRt_Id = 3;
    step(1'b0); chk("tuse_unused", 32'(ifStall), 32'd0);
    @(negedge clk);

    // Mult followed by mflo, counter cleared by a reset pulse in the start cycle
    clear_inputs(); mdStart_Ex = 1; mdUse_Id = 1;
    for (int k = 0; k <= 6; k++) begin
      step(k == 0);
      chk("mult_stall", 32'(ifStall), (k < 6) ? 32'd1 : 32'd0);
      chk("mult_count", 32'(mdCount), (k >= 1 && k <= 5) ? 32'(6 - k) : 32'd0);
      @(negedge clk);
      mdStart_Ex = 0;
    end
    chk("mult_stallcnt", 32'(stallCnt), 32'd6);

    // Div: busy for 11 cycles, count starts at 10
    clear_inputs(); mdStart_Ex = 1; mdIsDiv_Ex = 1;
    for (int k = 0; k <= 11; k++) begin
      step(1'b0);
      chk("div_busy", 32'(mdBusy), (k <= 10) ? 32'd1 : 32'd0);
      if (k == 1) chk("div_first_count", 32'(mdCount), 32'd10);
      @(negedge clk);
      mdStart_Ex = 0;
    end

    // Flush precedence over data stall and md start
    clear_inputs();
    rs_Id = 8; grfWa_Ex = 8; tnew_Ex = 2; mdStart_Ex = 1; excReq_Mem = 1;
    step(1'b0);
    chk("flush_prec", {29'd0, flush_Mem, ifStall, mdGo}, 32'd4);
    @(negedge clk);
    clear_inputs();
    step(1'b0);
    chk("flush_idle", 32'(mdBusy), 32'd0);
    @(negedge clk);

    // Async reset in the middle of a div, then a fresh start is accepted
    mdStart_Ex = 1; mdIsDiv_Ex = 1;
    step(1'b0); @(negedge clk);
    mdStart_Ex = 0;
    step(1'b0); @(negedge clk);
    step(1'b0); @(negedge clk);
    step(1'b1);
    chk("rst_mid_div", {30'd0, mdBusy, mdCount != 4'd0}, 32'd0);
    @(negedge clk);
    mdStart_Ex = 1; mdIsDiv_Ex = 0;
    step(1'b0);
    chk("restart_go", 32'(mdGo), 32'd1);
    @(negedge clk);

    // Randomized traffic against the model (small register range for frequent hits)
    for (int i = 0; i < 600; i++) begin
      rs_Id      = 5'($urandom_range(0, 3));
      rt_Id      = 5'($urandom_range(0, 3));
      grfWa_Ex   = 5'($urandom_range(0, 3));
      grfWa_Mem  = 5'($urandom_range(0, 3));
      tuseRs_Id  = 2'($urandom);
      tuseRt_Id  = 2'($urandom);
      tnew_Ex    = 2'($urandom);
      tnew_Mem   = 2'($urandom);
      mdUse_Id   = 1'($urandom);
      mdStart_Ex = ($urandom_range(0, 3) == 0);
      mdIsDiv_Ex = 1'($urandom);
      excReq_Mem = ($urandom_range(0, 9) == 0);
      eret_Mem   = ($urandom_range(0, 9) == 0);
      step($urandom_range(0, 39) == 0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
